// File: rtl/retire_unit.sv
// Retirement stage: drains in-order ROB commits, owns the retirement RAT,
// releases committed stores to the LSU and raises a flush on a committing fault.
module retire_unit #(
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned ROB_SIZE  = 16,
    parameter int unsigned ROB_W     = $clog2(ROB_SIZE),
    parameter int unsigned PHYS_W    = $clog2(PHYS_REGS),
    parameter int unsigned EPOCH_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               commit_valid,
    output logic               commit_ready,
    input  logic [ROB_W-1:0]   commit_rob_idx,
    input  logic               commit_uses_rd,
    input  logic [4:0]         commit_rd_arch,
    input  logic [PHYS_W-1:0]  commit_pd_new,
    input  logic               commit_is_store,
    input  logic               commit_exception,
    input  logic [31:0]        commit_pc,
    output logic               st_commit_valid,
    input  logic               st_commit_ready,
    output logic [ROB_W-1:0]   st_commit_rob_idx,
    output logic               flush_valid,
    output logic [ROB_W-1:0]   flush_rob_idx,
    output logic [EPOCH_W-1:0] flush_epoch,
    output logic [31:0]        trap_pc,
    input  logic [4:0]         dbg_arch,
    output logic [PHYS_W-1:0]  dbg_phys,
    output logic [63:0]        retired_count
);

    typedef enum logic [1:0] {StIdle, StStWait, StFlush} state_e;

    state_e              state_q, state_d;
    logic [PHYS_W-1:0]   rrat_q [ARCH_REGS];
    logic [PHYS_W-1:0]   rrat_d [ARCH_REGS];
    logic [63:0]         count_q, count_d;
    logic [EPOCH_W-1:0]  epoch_q, epoch_d;
    logic [ROB_W-1:0]    st_idx_q, st_idx_d;
    logic [ROB_W-1:0]    flush_idx_q, flush_idx_d;
    logic [31:0]         trap_pc_q, trap_pc_d;

    always_comb begin
        state_d      = state_q;
        rrat_d       = rrat_q;
        count_d      = count_q;
        epoch_d      = epoch_q;
        st_idx_d     = st_idx_q;
        flush_idx_d  = flush_idx_q;
        trap_pc_d    = trap_pc_q;
        commit_ready = 1'b0;
        case (state_q)
            StIdle: begin
                if (commit_valid) begin
                    if (commit_exception) begin
                        // Faults win over the store path and consume the entry silently.
                        commit_ready = 1'b1;
                        flush_idx_d  = commit_rob_idx;
                        trap_pc_d    = commit_pc;
                        epoch_d      = epoch_q + 1'b1;
                        state_d      = StFlush;
                    end else if (commit_is_store) begin
                        st_idx_d = commit_rob_idx;
                        state_d  = StStWait;
                    end else begin
                        commit_ready = 1'b1;
                        count_d      = count_q + 64'd1;
                        if (commit_uses_rd && commit_rd_arch != 5'd0) begin
                            rrat_d[commit_rd_arch] = commit_pd_new;
                        end
                    end
                end
            end
            StStWait: begin
                // Store retires on the same edge the LSU takes it.
                commit_ready = st_commit_ready;
                if (st_commit_ready) begin
                    count_d = count_q + 64'd1;
                    state_d = StIdle;
                end
            end
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            epoch_q     <= '0;
            st_idx_q    <= '0;
            flush_idx_q <= '0;
            trap_pc_q   <= '0;
            for (int i = 0; i < int'(ARCH_REGS); i++) begin
                rrat_q[i] <= PHYS_W'(i);
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            epoch_q     <= epoch_d;
            st_idx_q    <= st_idx_d;
            flush_idx_q <= flush_idx_d;
            trap_pc_q   <= trap_pc_d;
            rrat_q      <= rrat_d;
        end
    end

    assign st_commit_valid   = (state_q == StStWait);
    assign st_commit_rob_idx = st_idx_q;
    assign flush_valid       = (state_q == StFlush);
    assign flush_rob_idx     = flush_idx_q;
    assign flush_epoch       = epoch_q;
    assign trap_pc           = trap_pc_q;
    assign retired_count     = count_q;
    assign dbg_phys          = rrat_q[dbg_arch];

endmodule

// File: tb/tb_retire_unit.sv
// Self-checking bench for retire_unit: directed steps plus randomized commits
// against a plain-array reference of the retirement state.
module tb_retire_unit;

    localparam int ROB_W   = 4;
    localparam int PHYS_W  = 6;
    localparam int EPOCH_W = 3;

    logic               clk;
    logic               rst_n;
    logic               commit_valid;
    logic               commit_ready;
    logic [ROB_W-1:0]   commit_rob_idx;
    logic               commit_uses_rd;
    logic [4:0]         commit_rd_arch;
    logic [PHYS_W-1:0]  commit_pd_new;
    logic               commit_is_store;
    logic               commit_exception;
    logic [31:0]        commit_pc;
    logic               st_commit_valid;
    logic               st_commit_ready;
    logic [ROB_W-1:0]   st_commit_rob_idx;
    logic               flush_valid;
    logic [ROB_W-1:0]   flush_rob_idx;
    logic [EPOCH_W-1:0] flush_epoch;
    logic [31:0]        trap_pc;
    logic [4:0]         dbg_arch;
    logic [PHYS_W-1:0]  dbg_phys;
    logic [63:0]        retired_count;

    retire_unit #(
        .ARCH_REGS(32), .PHYS_REGS(64), .ROB_SIZE(16), .EPOCH_W(EPOCH_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_rob_idx(commit_rob_idx), .commit_uses_rd(commit_uses_rd),
        .commit_rd_arch(commit_rd_arch), .commit_pd_new(commit_pd_new),
        .commit_is_store(commit_is_store), .commit_exception(commit_exception),
        .commit_pc(commit_pc),
        .st_commit_valid(st_commit_valid), .st_commit_ready(st_commit_ready),
        .st_commit_rob_idx(st_commit_rob_idx),
        .flush_valid(flush_valid), .flush_rob_idx(flush_rob_idx),
        .flush_epoch(flush_epoch), .trap_pc(trap_pc),
        .dbg_arch(dbg_arch), .dbg_phys(dbg_phys), .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      n_checks = 0;
    int unsigned      n_errors = 0;
    int               m_rrat [32];
    longint unsigned  m_count;
    int               m_epoch;
    int               m_flush_idx;
    longint unsigned  m_trap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rrat[i] = i;
        m_count     = 0;
        m_epoch     = 0;
        m_flush_idx = 0;
        m_trap      = 0;
    endtask

    task automatic drive(input logic [ROB_W-1:0] rob, input logic uses, input logic [4:0] rd,
                         input logic [PHYS_W-1:0] pd, input logic st, input logic exc,
                         input logic [31:0] pc);
        commit_valid     = 1'b1;
        commit_rob_idx   = rob;
        commit_uses_rd   = uses;
        commit_rd_arch   = rd;
        commit_pd_new    = pd;
        commit_is_store  = st;
        commit_exception = exc;
        commit_pc        = pc;
    endtask

    // Holds the head empty so the clock edges it spans change nothing.
    task automatic check_rat(input string tag);
        commit_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dbg_arch = 5'(i);
            #1;
            chk($sformatf("%s_rat%0d", tag, i), 64'(dbg_phys), 64'(m_rrat[i]));
        end
    endtask

    task automatic do_plain(input logic [ROB_W-1:0] rob, input logic uses, input logic [4:0] rd,
                            input logic [PHYS_W-1:0] pd);
        @(negedge clk);
        drive(rob, uses, rd, pd, 1'b0, 1'b0, $urandom);
        #1;
        chk("plain_ready", 64'(commit_ready), 64'd1);
        @(posedge clk);
        if (uses && rd != 0) m_rrat[rd] = pd;
        m_count++;
        #1;
        commit_valid = 1'b0;
        dbg_arch = rd;
        #1;
        chk("plain_count", retired_count, m_count);
        chk("plain_rat", 64'(dbg_phys), 64'(m_rrat[rd]));
    endtask

    task automatic do_store(input logic [ROB_W-1:0] rob, input int stall);
        logic [4:0] rd;
        rd = 5'($urandom_range(1, 31));
        @(negedge clk);
        drive(rob, 1'b1, rd, 6'($urandom), 1'b1, 1'b0, $urandom);
        st_commit_ready = 1'b0;
        #1;
        chk("st_detect_ready", 64'(commit_ready), 64'd0);
        chk("st_detect_valid", 64'(st_commit_valid), 64'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            #1;
            chk("st_wait_valid", 64'(st_commit_valid), 64'd1);
            chk("st_wait_idx", 64'(st_commit_rob_idx), 64'(rob));
            chk("st_wait_ready", 64'(commit_ready), 64'd0);
        end
        @(negedge clk);
        st_commit_ready = 1'b1;
        #1;
        chk("st_acc_valid", 64'(st_commit_valid), 64'd1);
        chk("st_acc_idx", 64'(st_commit_rob_idx), 64'(rob));
        chk("st_acc_ready", 64'(commit_ready), 64'd1);
        @(posedge clk);
        m_count++;
        #1;
        commit_valid    = 1'b0;
        st_commit_ready = 1'b0;
        dbg_arch        = rd;
        #1;
        chk("st_count", retired_count, m_count);
        chk("st_done_valid", 64'(st_commit_valid), 64'd0);
        chk("st_no_rat", 64'(dbg_phys), 64'(m_rrat[rd]));
    endtask

    task automatic do_exc(input logic [ROB_W-1:0] rob, input logic [31:0] pc, input logic st);
        logic [4:0] rd;
        rd = 5'($urandom_range(1, 31));
        @(negedge clk);
        drive(rob, 1'b1, rd, 6'($urandom), st, 1'b1, pc);
        st_commit_ready = 1'($urandom);
        #1;
        chk("exc_ready", 64'(commit_ready), 64'd1);
        chk("exc_no_st", 64'(st_commit_valid), 64'd0);
        @(posedge clk);
        m_epoch     = (m_epoch + 1) % (1 << EPOCH_W);
        m_flush_idx = int'(rob);
        m_trap      = 64'(pc);
        @(negedge clk);
        drive(4'($urandom), 1'b1, 5'($urandom), 6'($urandom), 1'b0, 1'b0, $urandom);
        #1;
        chk("flush_valid", 64'(flush_valid), 64'd1);
        chk("flush_idx", 64'(flush_rob_idx), 64'(m_flush_idx));
        chk("flush_pc", 64'(trap_pc), m_trap);
        chk("flush_epoch", 64'(flush_epoch), 64'(m_epoch));
        chk("flush_ready", 64'(commit_ready), 64'd0);
        chk("flush_no_st", 64'(st_commit_valid), 64'd0);
        @(posedge clk);
        #1;
        commit_valid    = 1'b0;
        st_commit_ready = 1'b0;
        dbg_arch        = rd;
        #1;
        chk("flush_once", 64'(flush_valid), 64'd0);
        chk("exc_count", retired_count, m_count);
        chk("epoch_hold", 64'(flush_epoch), 64'(m_epoch));
        chk("exc_no_rat", 64'(dbg_phys), 64'(m_rrat[rd]));
    endtask

    task automatic do_idle();
        @(negedge clk);
        drive(4'($urandom), 1'b1, 5'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), $urandom);
        commit_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_count", retired_count, m_count);
        chk("idle_no_st", 64'(st_commit_valid), 64'd0);
        chk("idle_no_flush", 64'(flush_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        commit_valid = 1'b0; commit_rob_idx = '0; commit_uses_rd = 1'b0; commit_rd_arch = '0;
        commit_pd_new = '0; commit_is_store = 1'b0; commit_exception = 1'b0; commit_pc = '0;
        st_commit_ready = 1'b0; dbg_arch = '0;
        model_reset();
        #23 rst_n = 1'b1;
        @(negedge clk);
        check_rat("reset");
        chk("rst_st_valid", 64'(st_commit_valid), 64'd0);
        chk("rst_st_idx", 64'(st_commit_rob_idx), 64'd0);
        chk("rst_flush", 64'(flush_valid), 64'd0);
        chk("rst_flush_idx", 64'(flush_rob_idx), 64'd0);
        chk("rst_epoch", 64'(flush_epoch), 64'd0);
        chk("rst_trap", 64'(trap_pc), 64'd0);
        chk("rst_count", retired_count, 64'd0);

        do_plain(4'd0, 1'b1, 5'd5, 6'd40);
        do_plain(4'd1, 1'b1, 5'd0, 6'd41);
        do_plain(4'd2, 1'b1, 5'd5, 6'd42);
        chk("b2b_count", retired_count, 64'd3);
        check_rat("b2b");

        do_store(4'd7, 3);
        do_exc(4'd3, 32'h8000_0010, 1'b0);
        chk("first_epoch", 64'(flush_epoch), 64'd1);
        check_rat("exc");

        for (int i = 0; i < (1 << EPOCH_W); i++) do_exc(4'($urandom), $urandom, 1'b1);
        chk("epoch_wrap", 64'(flush_epoch), 64'd1);

        repeat (300) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4)      do_plain(4'($urandom), 1'($urandom), 5'($urandom), 6'($urandom));
            else if (r <= 6) do_store(4'($urandom), $urandom_range(0, 3));
            else if (r == 7) do_exc(4'($urandom), $urandom, 1'($urandom));
            else             do_idle();
        end
        check_rat("rand");

        // Reset in the middle of a store wait.
        @(negedge clk);
        drive(4'd9, 1'b1, 5'd3, 6'd50, 1'b1, 1'b0, 32'h0);
        st_commit_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_rst_st_valid", 64'(st_commit_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_st_valid", 64'(st_commit_valid), 64'd0);
        model_reset();
        check_rat("mid_rst");
        chk("mid_rst_count", retired_count, 64'd0);
        chk("mid_rst_epoch", 64'(flush_epoch), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst_st", 64'(st_commit_valid), 64'd0);
            chk("post_rst_flush", 64'(flush_valid), 64'd0);
        end
        do_plain(4'd0, 1'b1, 5'd7, 6'd33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
